// File: rtl/uart_disp_pkg.sv
// Shared types and ASCII constants for the UART display command parser.
// The echo path is enabled with the UART_DISP_ECHO_EN macro.
package uart_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HI      = 2'd1,
    LO      = 2'd2,
    TX_WAIT = 2'd3
  } state_e;

  localparam logic [7:0] CMD_DISP = 8'h44;
  localparam logic [7:0] CMD_CLR  = 8'h43;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] ACK      = 8'h4B;
  localparam logic [7:0] NAK      = 8'h45;

endpackage

// File: rtl/hex_ascii_dec.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble.
module hex_ascii_dec (
  input  logic [7:0] byte_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);

  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nibble_o = byte_i[3:0];
      is_hex_o = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      // Low bits of 'A'/'a' are 1, so adding 9 yields 0xA..0xF.
      nibble_o = byte_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end

endmodule

// File: rtl/uart_disp_ctrl.sv
// ASCII command parser driving the two-digit display ("D<hex><hex>" sets, "C" clears).
// Defining UART_DISP_ECHO_EN adds a K/E echo byte over a valid/ready tx port.
module uart_disp_ctrl
  import uart_disp_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0] RESET_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] disp_data,
  output logic       disp_blank,
  output logic       busy,
  output logic       cmd_err,
  output state_e     dbg_state
`ifdef UART_DISP_ECHO_EN
  ,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [7:0]    disp_q;
  logic          blank_q;
  logic          busy_q;
  logic          err_q;
  logic [3:0]    hi_q;
  logic [TW-1:0] tout_q;
`ifdef UART_DISP_ECHO_EN
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
`endif

  logic [3:0] nibble;
  logic       is_hex;
  logic       fail;
  logic       cmd_done;

  hex_ascii_dec u_dec (
    .byte_i   (rx_data),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

  // A protocol error or timeout aborts the command; cmd_done marks a completed command.
  always_comb begin
    fail     = 1'b0;
    cmd_done = 1'b0;
    case (state_q)
      IDLE: begin
        fail     = rx_valid && !(rx_data == CMD_DISP || rx_data == CMD_CLR ||
                                 rx_data == CR || rx_data == LF);
        cmd_done = rx_valid && (rx_data == CMD_CLR);
      end
      HI, LO: begin
        fail     = rx_valid ? !is_hex : (tout_q == TOUT_LAST);
        cmd_done = rx_valid && is_hex && (state_q == LO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      disp_q     <= RESET_VALUE;
      blank_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      hi_q       <= 4'h0;
      tout_q     <= '0;
`ifdef UART_DISP_ECHO_EN
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      if (fail) begin
        err_q  <= 1'b1;
        tout_q <= '0;
`ifdef UART_DISP_ECHO_EN
        state_q    <= TX_WAIT;
        busy_q     <= 1'b1;
        tx_data_q  <= NAK;
        tx_valid_q <= 1'b1;
`else
        state_q <= IDLE;
        busy_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            tout_q <= '0;
            if (rx_valid && rx_data == CMD_DISP) begin
              state_q <= HI;
              busy_q  <= 1'b1;
            end else if (rx_valid && rx_data == CMD_CLR) begin
              disp_q  <= RESET_VALUE;
              blank_q <= 1'b1;
            end
          end
          HI: begin
            if (rx_valid) begin
              hi_q    <= nibble;
              state_q <= LO;
              tout_q  <= '0;
            end else if (tout_q != {TW{1'b1}}) begin
              tout_q <= tout_q + 1'b1;
            end
          end
          LO: begin
            if (rx_valid) begin
              disp_q  <= {hi_q, nibble};
              blank_q <= 1'b0;
              tout_q  <= '0;
            end else if (tout_q != {TW{1'b1}}) begin
              tout_q <= tout_q + 1'b1;
            end
          end
`ifdef UART_DISP_ECHO_EN
          TX_WAIT: begin
            tout_q <= '0;
            err_q  <= rx_valid;
            if (tx_valid_q && tx_ready) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tout_q  <= '0;
          end
        endcase
        if (cmd_done) begin
`ifdef UART_DISP_ECHO_EN
          state_q    <= TX_WAIT;
          busy_q     <= 1'b1;
          tx_data_q  <= ACK;
          tx_valid_q <= 1'b1;
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
      end
    end
  end

  assign disp_data  = disp_q;
  assign disp_blank = blank_q;
  assign busy       = busy_q;
  assign cmd_err    = err_q;
  assign dbg_state  = state_q;
`ifdef UART_DISP_ECHO_EN
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
`endif

endmodule

// File: tb/tb_uart_disp_ctrl.sv
// Directed bench for uart_disp_ctrl with a short timeout (16 cycles).
// Covers UART_DISP_ECHO_EN as well when the macro is defined.
module tb_uart_disp_ctrl;
  import uart_disp_pkg::*;

`ifdef UART_DISP_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] disp_data;
  logic       disp_blank;
  logic       busy;
  logic       cmd_err;
  state_e     dbg_state;
`ifdef UART_DISP_ECHO_EN
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_disp_ctrl #(
    .TIMEOUT_CYCLES (16),
    .RESET_VALUE    (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .dbg_state  (dbg_state)
`ifdef UART_DISP_ECHO_EN
    ,
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: one-cycle strobe; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    check("rst_data", disp_data, 8'h00);
    check("rst_blank", disp_blank, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", cmd_err, 1'b0);
    check("rst_state", dbg_state, IDLE);
`ifdef UART_DISP_ECHO_EN
    check("rst_txv", tx_valid, 1'b0);
    check("rst_txd", tx_data, 8'h00);
`endif

    // D 3 A
    send_byte(8'h44);
    check("d_busy", busy, 1'b1);
    check("d_err", cmd_err, 1'b0);
    send_byte(8'h33);
    check("hi_busy", busy, 1'b1);
    check("hi_data", disp_data, 8'h00);
    send_byte(8'h41);
    check("d3a_data", disp_data, 8'h3A);
    check("d3a_blank", disp_blank, 1'b0);
    check("d3a_busy", busy, ECHO);
    check("d3a_err", cmd_err, 1'b0);

    // Lowercase hex then clear
    send_byte(8'h44); send_byte(8'h66); send_byte(8'h30);
    check("df0_data", disp_data, 8'hF0);
    send_byte(8'h43);
    check("clr_data", disp_data, 8'h00);
    check("clr_blank", disp_blank, 1'b1);
    check("clr_err", cmd_err, 1'b0);

    // Bad nibble keeps the display
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h41);
    check("re3a_data", disp_data, 8'h3A);
    send_byte(8'h44); send_byte(8'h47);
    check("dg_err", cmd_err, 1'b1);
    check("dg_busy", busy, ECHO);
    check("dg_data", disp_data, 8'h3A);
    check("dg_blank", disp_blank, 1'b0);
    idle(1);
    check("dg_pulse", cmd_err, 1'b0);
    send_byte(8'h58);
    check("x_err", cmd_err, 1'b1);
    send_byte(8'h0D);
    check("cr_err", cmd_err, 1'b0);
    send_byte(8'h0A);
    check("lf_err", cmd_err, 1'b0);
    check("lf_data", disp_data, 8'h3A);

    // Back-to-back strobes of stray bytes
    @(negedge clk);
    rx_data = 8'h58; rx_valid = 1'b1;
    @(negedge clk);
    check("b2b_err0", cmd_err, 1'b1);
    rx_data = 8'h59;
    @(negedge clk);
    check("b2b_err1", cmd_err, 1'b1);
    rx_valid = 1'b0;
    @(negedge clk);
    check("b2b_err2", cmd_err, 1'b0);

    // Timeout: 16 idle cycles in HI
    send_byte(8'h44);
    idle(15);
    check("to_pre_busy", busy, 1'b1);
    check("to_pre_err", cmd_err, 1'b0);
    idle(1);
    check("to_err", cmd_err, 1'b1);
    check("to_busy", busy, ECHO);
    check("to_data", disp_data, 8'h3A);
    idle(1);
    check("to_pulse", cmd_err, 1'b0);

    // Byte landing on the expiry cycle wins, and restarts the count
    send_byte(8'h44);
    idle(14);
    send_byte(8'h35);
    check("exp_err", cmd_err, 1'b0);
    check("exp_busy", busy, 1'b1);
    idle(14);
    send_byte(8'h36);
    check("exp_data", disp_data, 8'h56);
    check("exp_err2", cmd_err, 1'b0);

    // Reset mid-command
    send_byte(8'h44);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_data", disp_data, 8'h00);
    check("mrst_blank", disp_blank, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_err", cmd_err, 1'b0);
    send_byte(8'h44); send_byte(8'h31); send_byte(8'h32);
    check("d12_data", disp_data, 8'h12);
    check("d12_err", cmd_err, 1'b0);

`ifdef UART_DISP_ECHO_EN
    idle(2);
    tx_ready = 1'b0;
    send_byte(8'h44); send_byte(8'h31); send_byte(8'h32);
    for (int i = 0; i < 5; i++) begin
      check("echo_txv", tx_valid, 1'b1);
      check("echo_txd", tx_data, 8'h4B);
      check("echo_busy", busy, 1'b1);
      @(negedge clk);
    end
    send_byte(8'h5A);
    check("echo_drop_err", cmd_err, 1'b1);
    check("echo_drop_txd", tx_data, 8'h4B);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("echo_hs_txv", tx_valid, 1'b0);
    check("echo_hs_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("echo_no_second", tx_valid, 1'b0);
    end
    tx_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
